rgu_rst_sequencer: RTL and testbench
====================================

# rgu_rst_sequencer

Reset sequencer that sits between the RGU APB register block and the per-domain reset nets.
- On a software reset request (SWRST register write) or a global request (RGU_GLB), it asserts the selected domain resets together and holds them for a programmable time (RGU_TIMER0).
- It then releases them one at a time in fixed priority order, spaced by a programmable gap (RGU_TIMER1).
- It also performs the power-on release sequence after PRESET and keeps sticky status for RGU_RST_STATUS.

## Interface
Parameters:
- NUM_DOM, 23: number of reset domains. Bit i corresponds to the SWRST register at 0x010 + 4*i.
- CNT_W, 16: width of the hold and stagger counters.

Ports:
- PCLK  in  1  single clock for the block.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  software reset request, qualified with req_mask.
- req_mask  in  NUM_DOM  domains to reset.
- req_ready  out  1  high only in IDLE with glb_rst low. A request is accepted on an edge where req_valid && req_ready.
- glb_rst  in  1  level global reset request covering all domains. Takes priority over everything else.
- hold_cycles  in  CNT_W  assert-hold time, from RGU_TIMER0[CNT_W-1:0].
- stagger_cycles  in  CNT_W  gap between successive releases, from RGU_TIMER1[CNT_W-1:0].
- status_clr  in  1  one-cycle pulse that clears rst_status.
- dom_rst_n  out  NUM_DOM  active-low domain resets. Reset value all 0 (all domains in reset).
- busy  out  1  high in any state other than IDLE. Reset value 1.
- done  out  1  one-cycle pulse when a sequence completes. Reset value 0.
- rst_status  out  NUM_DOM  sticky "domain was reset" bits. Reset value all 1.

## Operation
- States: IDLE, ASSERT, HOLD, RELEASE, DONE. Registers:
  - pending[NUM_DOM]: domains still held in reset.
  - cnt[CNT_W]: down-counter for hold and stagger timing.
- PRESET: state=HOLD, pending=all 1, cnt=max(hold_cycles,1)-1 sampled out of reset. This performs the power-on release with no software action.
- IDLE with accepted request:
  - req_mask != 0: pending=req_mask, clear the matching dom_rst_n bits, go to ASSERT.
  - req_mask == 0: go straight to DONE; dom_rst_n unchanged.
- ASSERT: lasts 1 cycle.
  - Load cnt=max(hold_cycles,1)-1 and go to HOLD.
  - Set rst_status bits for pending.
- HOLD: decrement cnt. At cnt==0 go to RELEASE with cnt=0.
- RELEASE: when cnt==0:
  - Set dom_rst_n for the lowest-index pending bit and clear that pending bit.
  - Reload cnt=max(stagger_cycles,1)-1.
  - If this was the last pending bit, go to DONE.
  - When cnt!=0: decrement cnt.
- DONE: done=1 for this cycle only, then go to IDLE.
- glb_rst high, in any state:
  - Next edge: state=ASSERT, pending=all 1, dom_rst_n=all 0, rst_status=all 1.
  - State stays in ASSERT while glb_rst remains high.
  - The normal flow resumes on the first edge with glb_rst low.
- Timer inputs are sampled only at counter load. Changes mid-count have no effect.
- Domains not in pending are never touched by a sequence.
- rst_status: status_clr clears all bits. A set on the same edge wins for the set bits.

## Timing
- Request accepted at edge E0:
  - dom_rst_n low after E0 (ASSERT).
  - HOLD begins at E1.
  - First release at edge E1+H, where H=max(hold_cycles,1).
- Each subsequent release follows S=max(stagger_cycles,1) cycles after the previous one.
- For k domains:
  - The last release is at E1+H+(k-1)*S.
  - done is high in the cycle after the last release.
  - req_ready returns high one cycle after that.
- req_valid while busy is not accepted. The requester holds req_valid until req_ready.
- Reset-domain hold is therefore always at least 2 cycles, even with zero timers.
- PRESET asserted mid-sequence: all outputs return to reset values asynchronously.

## Structure
- Package rgu_pkg:
  - state enum rgu_seq_state_e.
  - NUM_DOM and CNT_W defaults.
  - Domain index localparams (SB=0, SYS=1, … HEAVY=22).
  - SWRST base offset 12'h010.
- Sub-module rgu_lsb_pick: combinational lowest-set-bit one-hot finder over NUM_DOM. It is reused by the register block for status.

## Test plan
- PRESET deasserted with hold=3, stagger=2, NUM_DOM=4:
  - dom_rst_n=4'b0000 until the first release.
  - Bits release in order 0,1,2,3 at 2-cycle spacing.
  - done pulses once; rst_status=4'b1111.
- IDLE, req_mask=4'b0100, hold=5: dom_rst_n[2] low for exactly 6 cycles; the other bits stay 1; done pulses once.
- hold=0, stagger=0, req_mask=4'b1010: bit1 is released at E2 and bit3 at E3; done is high in the cycle after E3.
- glb_rst pulsed for 3 cycles during RELEASE of mask 4'b0011:
  - All dom_rst_n go 0; pending=4'b1111.
  - Full restart after glb_rst falls; bits 2 and 3 are also released.
- req_valid held during busy: not accepted until req_ready=1; exactly one sequence runs per accepted request; req_mask=0 gives a done pulse only.
- status_clr on the same edge as ASSERT of mask 4'b0001: rst_status=4'b0001 afterwards.

Source files
------------

// File: rtl/rgu_pkg.sv
// ---------------------------------------------------------------------------
// rgu_pkg
//
// Shared definitions for the reset generation unit (RGU) slice.
//
// Contents:
//   rgu_seq_state_e     : state encoding of the reset sequencer FSM
//   RGU_NUM_DOM         : default number of reset domains
//   RGU_CNT_W           : default width of the hold/stagger counters
//   RGU_DOM_*           : bit index of each reset domain in masks and nets
//   RGU_SWRST_BASE      : APB offset of the SWRST register of domain 0
//   rgu_swrst_offset()  : APB offset of the SWRST register of a domain
// ---------------------------------------------------------------------------
package rgu_pkg;

   // Default sizing of the sequencer.
   localparam int RGU_NUM_DOM = 23;
   localparam int RGU_CNT_W   = 16;

   // SWRST registers sit one word apart, starting at this offset.
   localparam logic [11:0] RGU_SWRST_BASE = 12'h010;

   // Domain bit positions. Lower index means earlier release.
   localparam int RGU_DOM_SB      = 0;
   localparam int RGU_DOM_SYS     = 1;
   localparam int RGU_DOM_BUS     = 2;
   localparam int RGU_DOM_CPU0    = 3;
   localparam int RGU_DOM_CPU1    = 4;
   localparam int RGU_DOM_DBG     = 5;
   localparam int RGU_DOM_DMA     = 6;
   localparam int RGU_DOM_SRAM    = 7;
   localparam int RGU_DOM_ROM     = 8;
   localparam int RGU_DOM_FLASH   = 9;
   localparam int RGU_DOM_PERIPH0 = 10;
   localparam int RGU_DOM_PERIPH1 = 11;
   localparam int RGU_DOM_UART    = 12;
   localparam int RGU_DOM_SPI     = 13;
   localparam int RGU_DOM_I2C     = 14;
   localparam int RGU_DOM_TIMER   = 15;
   localparam int RGU_DOM_GPIO    = 16;
   localparam int RGU_DOM_USB     = 17;
   localparam int RGU_DOM_ETH     = 18;
   localparam int RGU_DOM_ADC     = 19;
   localparam int RGU_DOM_CAN     = 20;
   localparam int RGU_DOM_LCD     = 21;
   localparam int RGU_DOM_HEAVY   = 22;

   // Sequencer states.
   //   IDLE    : waiting for a software request
   //   ASSERT  : selected resets just went low; loads the hold timer
   //   HOLD    : counting down the assert-hold time
   //   RELEASE : releasing pending domains one by one, stagger apart
   //   DONE    : one-cycle completion pulse
   typedef enum logic [2:0] {
      RGU_IDLE    = 3'd0,
      RGU_ASSERT  = 3'd1,
      RGU_HOLD    = 3'd2,
      RGU_RELEASE = 3'd3,
      RGU_DONE    = 3'd4
   } rgu_seq_state_e;

   // APB offset of the SWRST register belonging to domain 'dom'.
   function automatic logic [11:0] rgu_swrst_offset(input int unsigned dom);
      return RGU_SWRST_BASE + 12'(dom * 4);
   endfunction

endpackage

// File: rtl/rgu_lsb_pick.sv
// ---------------------------------------------------------------------------
// rgu_lsb_pick
//
// Purely combinational lowest-set-bit finder. Returns a one-hot vector with
// only the lowest set bit of 'vec' kept, or all zeros when 'vec' is zero.
// The sequencer uses it to choose the next domain to release; the register
// block uses the same cell when reporting status.
//
// Parameters:
//   WIDTH  : vector width (defaults to the number of reset domains)
//
// Ports:
//   vec     in   WIDTH  candidate bits
//   onehot  out  WIDTH  lowest set bit of vec, one-hot
// ---------------------------------------------------------------------------
module rgu_lsb_pick
   import rgu_pkg::*;
#(
   parameter int WIDTH = RGU_NUM_DOM
) (
   input  logic [WIDTH-1:0] vec,
   output logic [WIDTH-1:0] onehot
);

   // Two's-complement trick: vec & -vec isolates the lowest set bit and
   // yields zero when no bit is set, so no separate empty check is needed.
   assign onehot = vec & (~vec + WIDTH'(1));

endmodule

// File: rtl/rgu_rst_sequencer.sv
// ---------------------------------------------------------------------------
// rgu_rst_sequencer
//
// Sits between the RGU APB register block and the per-domain reset nets.
// A software request (SWRST write) or the global request (RGU_GLB) pulls
// the selected domain resets low together, holds them for the programmed
// hold time (RGU_TIMER0) and then releases them one by one, lowest index
// first, spaced by the programmed stagger (RGU_TIMER1). Out of PRESET the
// block runs the same release sequence over all domains on its own, so
// the chip comes up without software help. Sticky per-domain status is
// kept for RGU_RST_STATUS.
//
// Parameters:
//   NUM_DOM : number of reset domains (bit i <-> SWRST at 0x010 + 4*i)
//   CNT_W   : width of the hold / stagger counters
//
// Ports:
//   PCLK            in   1        block clock
//   PRESET          in   1        asynchronous active-high reset
//   req_valid       in   1        software reset request
//   req_mask        in   NUM_DOM  domains to reset with req_valid
//   req_ready       out  1        request can be accepted this cycle
//   glb_rst         in   1        level global request, highest priority
//   hold_cycles     in   CNT_W    assert-hold time (0 behaves as 1)
//   stagger_cycles  in   CNT_W    gap between releases (0 behaves as 1)
//   status_clr      in   1        clears rst_status
//   dom_rst_n       out  NUM_DOM  active-low domain resets
//   busy            out  1        sequencer not idle
//   done            out  1        one-cycle pulse at end of a sequence
//   rst_status      out  NUM_DOM  sticky "domain was reset" bits
// ---------------------------------------------------------------------------
module rgu_rst_sequencer
   import rgu_pkg::*;
#(
   parameter int NUM_DOM = RGU_NUM_DOM,
   parameter int CNT_W   = RGU_CNT_W
) (
   input  logic               PCLK,
   input  logic               PRESET,
   input  logic               req_valid,
   input  logic [NUM_DOM-1:0] req_mask,
   output logic               req_ready,
   input  logic               glb_rst,
   input  logic [CNT_W-1:0]   hold_cycles,
   input  logic [CNT_W-1:0]   stagger_cycles,
   input  logic               status_clr,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               busy,
   output logic               done,
   output logic [NUM_DOM-1:0] rst_status
);

   rgu_seq_state_e     state_q;
   rgu_seq_state_e     state_d;
   logic [NUM_DOM-1:0] pending_q;
   logic [NUM_DOM-1:0] pending_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [NUM_DOM-1:0] dom_rst_n_q;
   logic [NUM_DOM-1:0] dom_rst_n_d;
   logic [NUM_DOM-1:0] rst_status_q;
   logic [NUM_DOM-1:0] rst_status_d;
   logic               arm_q;
   logic               arm_d;

   logic [CNT_W-1:0]   hold_load;
   logic [CNT_W-1:0]   stagger_load;
   logic [NUM_DOM-1:0] release_bit;
   logic [NUM_DOM-1:0] pending_left;
   logic [NUM_DOM-1:0] status_set;
   logic               release_now;
   logic               accept;

   // A programmed time of zero is treated as one cycle, so the counters
   // are always loaded with max(t,1)-1 and count down to zero.
   assign hold_load    = (hold_cycles == '0)    ? '0 : hold_cycles - CNT_W'(1);
   assign stagger_load = (stagger_cycles == '0) ? '0 : stagger_cycles - CNT_W'(1);

   // The next domain to release is always the lowest-index pending one,
   // which gives the fixed release priority order.
   rgu_lsb_pick #(
      .WIDTH (NUM_DOM)
   ) u_lsb_pick (
      .vec    (pending_q),
      .onehot (release_bit)
   );

   assign pending_left = pending_q & ~release_bit;

   // Handshake and status outputs decode straight from the state. The
   // global request blocks acceptance even in IDLE because it is about to
   // take the sequencer over anyway.
   assign req_ready  = (state_q == RGU_IDLE) && !glb_rst;
   assign accept     = req_valid && req_ready;
   assign busy       = (state_q != RGU_IDLE);
   assign done       = (state_q == RGU_DONE);
   assign dom_rst_n  = dom_rst_n_q;
   assign rst_status = rst_status_q;

   // State and datapath registers. Reset lands directly in HOLD with every
   // domain pending and every reset asserted, so the power-on release runs
   // without software. The hold timer cannot be sampled while PRESET is
   // high, so arm_q marks that the first clock out of reset must load it.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= RGU_HOLD;
         pending_q    <= '1;
         cnt_q        <= '0;
         dom_rst_n_q  <= '0;
         rst_status_q <= '1;
         arm_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         cnt_q        <= cnt_d;
         dom_rst_n_q  <= dom_rst_n_d;
         rst_status_q <= rst_status_d;
         arm_q        <= arm_d;
      end
   end

   // Next-state and datapath logic.
   //
   // The global request overrides every state: all domains go back into
   // reset and the FSM parks in ASSERT until the request drops, after
   // which the normal ASSERT -> HOLD -> RELEASE flow restarts over all
   // domains.
   //
   // The edge on which the hold counter expires is also the first release
   // edge, so HOLD releases directly at cnt==0 instead of spending an extra
   // cycle in RELEASE first. This keeps the first release exactly
   // max(hold,1) cycles after HOLD is entered. RELEASE uses the same
   // release path for the following domains.
   //
   // Status bits are set when a sequence actually asserts its domains; a
   // clear on the same edge only wipes bits that are not being set.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      cnt_d       = cnt_q;
      dom_rst_n_d = dom_rst_n_q;
      arm_d       = arm_q;
      status_set  = '0;
      release_now = 1'b0;

      if (glb_rst) begin
         state_d     = RGU_ASSERT;
         pending_d   = '1;
         dom_rst_n_d = '0;
         arm_d       = 1'b0;
         status_set  = '1;
      end else begin
         case (state_q)
            RGU_IDLE: begin
               if (accept) begin
                  if (req_mask != '0) begin
                     pending_d   = req_mask;
                     dom_rst_n_d = dom_rst_n_q & ~req_mask;
                     state_d     = RGU_ASSERT;
                  end else begin
                     state_d     = RGU_DONE;
                  end
               end
            end

            RGU_ASSERT: begin
               cnt_d      = hold_load;
               status_set = pending_q;
               state_d    = RGU_HOLD;
            end

            RGU_HOLD: begin
               if (arm_q) begin
                  cnt_d = hold_load;
                  arm_d = 1'b0;
               end else if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  release_now = 1'b1;
               end
            end

            RGU_RELEASE: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  release_now = 1'b1;
               end
            end

            RGU_DONE: begin
               state_d = RGU_IDLE;
            end

            default: begin
               state_d = RGU_IDLE;
            end
         endcase

         if (release_now) begin
            dom_rst_n_d = dom_rst_n_q | release_bit;
            pending_d   = pending_left;
            cnt_d       = stagger_load;
            state_d     = (pending_left == '0) ? RGU_DONE : RGU_RELEASE;
         end
      end

      rst_status_d = (status_clr ? '0 : rst_status_q) | status_set;
   end

endmodule

// File: tb/tb_rgu_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rgu_rst_sequencer
//
// Self-checking bench for rgu_rst_sequencer with four domains. A table of
// software requests with hand-computed release edges drives the main loop;
// power-on, global request, busy handshake, same-edge status clear and
// mid-sequence PRESET are written out as separate sequences. Edges are
// numbered from the accepting edge E0; outputs are sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_rgu_rst_sequencer;

   localparam int ND = 4;
   localparam int CW = 16;

   logic          PCLK = 1'b0;
   logic          PRESET = 1'b0;
   logic          req_valid = 1'b0;
   logic [ND-1:0] req_mask = '0;
   logic          req_ready;
   logic          glb_rst = 1'b0;
   logic [CW-1:0] hold_cycles = 16'd3;
   logic [CW-1:0] stagger_cycles = 16'd2;
   logic          status_clr = 1'b0;
   logic [ND-1:0] dom_rst_n;
   logic          busy;
   logic          done;
   logic [ND-1:0] rst_status;

   int total = 0;
   int bad = 0;

   // One table entry per software request. rel[i] is the edge (counted
   // from the accepting edge E0) after which domain i is released;
   // done_edge is the edge after which done is high.
   typedef struct {
      string             name;
      logic [ND-1:0]     mask;
      logic [CW-1:0]     hold;
      logic [CW-1:0]     stagger;
      logic [ND-1:0][7:0] rel;
      int                done_edge;
      logic [ND-1:0]     exp_status;
   } vec_t;

   vec_t vecs[6];

   rgu_rst_sequencer #(
      .NUM_DOM (ND),
      .CNT_W   (CW)
   ) dut (
      .PCLK           (PCLK),
      .PRESET         (PRESET),
      .req_valid      (req_valid),
      .req_mask       (req_mask),
      .req_ready      (req_ready),
      .glb_rst        (glb_rst),
      .hold_cycles    (hold_cycles),
      .stagger_cycles (stagger_cycles),
      .status_clr     (status_clr),
      .dom_rst_n      (dom_rst_n),
      .busy           (busy),
      .done           (done),
      .rst_status     (rst_status)
   );

   // 10-unit clock period.
   always #5 PCLK = ~PCLK;

   // Hard stop in case something wedges the stimulus.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Present one request before the next edge; that edge is E0.
   task automatic applyStimulus(input logic [ND-1:0] mask, input logic [CW-1:0] hold,
                                input logic [CW-1:0] stagger);
      @(negedge PCLK);
      req_mask       = mask;
      hold_cycles    = hold;
      stagger_cycles = stagger;
      req_valid      = 1'b1;
      @(posedge PCLK);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic pulseClear();
      @(negedge PCLK);
      status_clr = 1'b1;
      @(posedge PCLK);
      #1;
      status_clr = 1'b0;
   endtask

   task automatic stepEdge();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      logic [ND-1:0] exp_dom;
      int            dones;
      bit            seen;

      vecs[0] = '{"single_b2",  4'b0100, 16'd5, 16'd2, {8'd0, 8'd6, 8'd0, 8'd0},   6, 4'b0100};
      vecs[1] = '{"zero_tmr",   4'b1010, 16'd0, 16'd0, {8'd3, 8'd0, 8'd2, 8'd0},   3, 4'b1010};
      vecs[2] = '{"all_four",   4'b1111, 16'd3, 16'd2, {8'd10, 8'd8, 8'd6, 8'd4}, 10, 4'b1111};
      vecs[3] = '{"pair_low",   4'b0011, 16'd1, 16'd4, {8'd0, 8'd0, 8'd6, 8'd2},   6, 4'b0011};
      vecs[4] = '{"ends",       4'b1001, 16'd2, 16'd1, {8'd4, 8'd0, 8'd0, 8'd3},   4, 4'b1001};
      vecs[5] = '{"empty",      4'b0000, 16'd4, 16'd4, {8'd0, 8'd0, 8'd0, 8'd0},   0, 4'b0000};

      // Reset values while PRESET is high.
      #1;
      PRESET = 1'b1;
      #2;
      checkOutput("rst_dom", dom_rst_n, 4'b0000);
      checkOutput("rst_busy", busy, 1'b1);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_status", rst_status, 4'b1111);
      checkOutput("rst_ready", req_ready, 1'b0);

      // Power-on release, hold=3 stagger=2. The first edge P1 out of reset
      // loads the hold timer, so releases land at P4, P6, P8, P10.
      @(negedge PCLK);
      @(negedge PCLK);
      PRESET = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         stepEdge();
         for (int i = 0; i < ND; i++) exp_dom[i] = (k >= 4 + 2 * i);
         checkOutput($sformatf("por_dom_p%0d", k), dom_rst_n, exp_dom);
         checkOutput($sformatf("por_done_p%0d", k), done, k == 10);
      end
      checkOutput("por_busy", busy, 1'b0);
      checkOutput("por_ready", req_ready, 1'b1);
      checkOutput("por_status", rst_status, 4'b1111);

      // Table-driven software requests.
      for (int v = 0; v < 6; v++) begin
         pulseClear();
         checkOutput({vecs[v].name, "_ready0"}, req_ready, 1'b1);
         applyStimulus(vecs[v].mask, vecs[v].hold, vecs[v].stagger);
         for (int k = 0; k <= vecs[v].done_edge + 1; k++) begin
            if (k > 0) stepEdge();
            exp_dom = 4'b1111;
            for (int i = 0; i < ND; i++)
               if (vecs[v].mask[i] && (k < int'(vecs[v].rel[i]))) exp_dom[i] = 1'b0;
            checkOutput($sformatf("%s_dom_e%0d", vecs[v].name, k), dom_rst_n, exp_dom);
            checkOutput($sformatf("%s_done_e%0d", vecs[v].name, k), done,
                        k == vecs[v].done_edge);
         end
         checkOutput({vecs[v].name, "_ready1"}, req_ready, 1'b1);
         checkOutput({vecs[v].name, "_status"}, rst_status, vecs[v].exp_status);
      end

      // req_valid held high with mask 0001 and zero timers: accepts at
      // E0, E4, E8; done after E2, E6, E10; idle after E3, E7, E11.
      @(negedge PCLK);
      req_mask       = 4'b0001;
      hold_cycles    = 16'd0;
      stagger_cycles = 16'd0;
      req_valid      = 1'b1;
      dones = 0;
      for (int e = 0; e <= 11; e++) begin
         stepEdge();
         if (done) dones++;
         checkOutput($sformatf("held_busy_e%0d", e), busy, (e % 4) != 3);
         checkOutput($sformatf("held_done_e%0d", e), done, (e % 4) == 2);
      end
      req_valid = 1'b0;
      checkOutput("held_dones", dones, 3);
      stepEdge();
      checkOutput("held_idle", busy, 1'b0);
      checkOutput("held_dom", dom_rst_n, 4'b1111);

      // Global request for 3 edges during RELEASE of mask 0011 (hold=1,
      // stagger=4). After the restart at E6 all four domains release at
      // E7, E11, E15, E19.
      pulseClear();
      applyStimulus(4'b0011, 16'd1, 16'd4);
      stepEdge();
      stepEdge();
      checkOutput("glb_pre_dom", dom_rst_n, 4'b1101);
      @(negedge PCLK);
      glb_rst = 1'b1;
      #1;
      checkOutput("glb_ready", req_ready, 1'b0);
      for (int k = 3; k <= 5; k++) begin
         stepEdge();
         checkOutput($sformatf("glb_dom_e%0d", k), dom_rst_n, 4'b0000);
         checkOutput($sformatf("glb_busy_e%0d", k), busy, 1'b1);
         checkOutput($sformatf("glb_status_e%0d", k), rst_status, 4'b1111);
      end
      glb_rst = 1'b0;
      for (int k = 6; k <= 20; k++) begin
         stepEdge();
         for (int i = 0; i < ND; i++) exp_dom[i] = (k >= 7 + 4 * i);
         checkOutput($sformatf("glb_dom_e%0d", k), dom_rst_n, exp_dom);
         checkOutput($sformatf("glb_done_e%0d", k), done, k == 19);
      end
      checkOutput("glb_ready_end", req_ready, 1'b1);
      checkOutput("glb_status_end", rst_status, 4'b1111);

      // status_clr on the ASSERT edge of mask 0001: the set wins for bit 0,
      // every other bit clears.
      applyStimulus(4'b0001, 16'd0, 16'd0);
      @(negedge PCLK);
      status_clr = 1'b1;
      stepEdge();
      status_clr = 1'b0;
      checkOutput("clr_status", rst_status, 4'b0001);
      stepEdge();
      stepEdge();
      checkOutput("clr_ready", req_ready, 1'b1);

      // PRESET in the middle of a hold: outputs return to reset values
      // without waiting for a clock edge, then power-on release runs again.
      applyStimulus(4'b0110, 16'd10, 16'd1);
      stepEdge();
      stepEdge();
      #1;
      PRESET = 1'b1;
      #1;
      checkOutput("mid_dom", dom_rst_n, 4'b0000);
      checkOutput("mid_busy", busy, 1'b1);
      checkOutput("mid_done", done, 1'b0);
      checkOutput("mid_status", rst_status, 4'b1111);
      checkOutput("mid_ready", req_ready, 1'b0);
      @(negedge PCLK);
      PRESET = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         stepEdge();
         if (done) seen = 1'b1;
      end
      checkOutput("mid_por_done", seen, 1'b1);
      checkOutput("mid_por_dom", dom_rst_n, 4'b1111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
